// File: rtl/ch2_4piso.sv
// ch2_4piso: parallel-in / serial-out converter with a one-word holding buffer.
// A parallel word is accepted on a rising CLK edge where LOAD=1 and READY=1.
// Its bits then appear on SOUT, one per cycle, starting the next cycle.
// A word offered while another is shifting is parked in the holding buffer.
// Back-to-back words stream with no idle gap between them.
//
// Ports:
//   CLK        - clock; all state updates on the rising edge
//   RESETN     - asynchronous active-low reset
//   LOAD       - parallel-word offer
//   DATA_IN    - parallel word, sampled only on acceptance
//   READY      - word can be accepted this cycle (holding buffer not full)
//   SOUT       - serial data bit
//   SOUT_VALID - SOUT carries a valid data bit
//   SOUT_LAST  - SOUT carries the final bit of a word
module ch2_4piso #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic             READY,
  output logic             SOUT,
  output logic             SOUT_VALID,
  output logic             SOUT_LAST
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [WIDTH-1:0] hold, hold_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             full, full_d;

  logic [WIDTH-1:0] shifted;
  logic             is_last;
  logic             accept;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
      sreg  <= '0;
      hold  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
    end else begin
      state <= state_d;
      sreg  <= sreg_d;
      hold  <= hold_d;
      cnt   <= cnt_d;
      full  <= full_d;
    end
  end

  always_comb begin
    state_d    = state;
    sreg_d     = sreg;
    hold_d     = hold;
    cnt_d      = cnt;
    full_d     = full;
    shifted    = '0;
    is_last    = 1'b0;
    accept     = LOAD && !full;
    READY      = !full;
    SOUT       = 1'b0;
    SOUT_VALID = 1'b0;
    SOUT_LAST  = 1'b0;

    if (MSB_FIRST) shifted = {sreg[WIDTH-2:0], 1'b0};
    else           shifted = {1'b0, sreg[WIDTH-1:1]};

    case (state)
      IDLE: begin
        if (accept) begin
          sreg_d  = DATA_IN;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        is_last    = (cnt == CW'(WIDTH - 1));
        SOUT       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        SOUT_VALID = 1'b1;
        SOUT_LAST  = is_last;
        if (is_last) begin
          // Word boundary: a buffered word has priority; with an empty
          // buffer a word offered now goes straight into the shifter.
          cnt_d = '0;
          if (full) begin
            sreg_d = hold;
            full_d = 1'b0;
          end else if (LOAD) begin
            sreg_d = DATA_IN;
          end else begin
            sreg_d  = shifted;
            state_d = IDLE;
          end
        end else begin
          sreg_d = shifted;
          cnt_d  = cnt + CW'(1);
          if (accept) begin
            hold_d = DATA_IN;
            full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
